// File: rtl/tbre_pkg.sv
// Shared definitions for the TBRE programming front-end: register map,
// STATUS bit positions, the mmreg_corein word layout and controller states.
package tbre_pkg;

    localparam logic [3:0] REG_START  = 4'h0;
    localparam logic [3:0] REG_END    = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_TIMEOUT = 3;

    typedef struct packed {
        logic [62:0] pad;
        logic        go;
        logic [31:0] end_addr;
        logic [31:0] start_addr;
    } tbre_mmreg_in_t;

    typedef enum logic [1:0] {IDLE, KICK, ACK, BUSY} tbre_ctrl_state_e;

endpackage

// File: rtl/tbre_range_chk.sv
// Combinational legality check of a requested walk range (inclusive end)
// against the permitted address window.
module tbre_range_chk
    import tbre_pkg::*;
#(
    parameter logic [31:0] AddrMin = 32'h8000_0000,
    parameter logic [31:0] AddrMax = 32'h8003_fff8
) (
    input  logic [31:0] start_addr,
    input  logic [31:0] end_addr,
    output logic        legal
);

    assign legal = (start_addr >= AddrMin) && (end_addr <= AddrMax) &&
                   (end_addr >= start_addr);

endmodule

// File: rtl/tbre_mmreg_ctrl.sv
// Register-bus front-end that programs and sequences the TBRE engine.
// Optional BUSY watchdog enabled by defining TBRE_CTRL_TIMEOUT_EN.
module tbre_mmreg_ctrl
    import tbre_pkg::*;
#(
    parameter int          GoPulseCycles = 2,
    parameter int          AckWaitCycles = 16,
    parameter logic [31:0] AddrMin       = 32'h8000_0000,
    parameter logic [31:0] AddrMax       = 32'h8003_fff8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         reg_req_i,
    input  logic         reg_we_i,
    input  logic [3:0]   reg_addr_i,
    input  logic [31:0]  reg_wdata_i,
    output logic [31:0]  reg_rdata_o,
    output logic         reg_rvalid_o,
    output logic [127:0] mmreg_corein_o,
    input  logic [63:0]  mmreg_coreout_i,
    output logic         irq_o
);

    localparam logic [2:0]  GoLoad  = 3'(GoPulseCycles - 1);
    localparam logic [15:0] AckLoad = 16'(AckWaitCycles - 1);

    logic [31:0]      start_q, end_q;
    logic             irq_en_q, go_q, done_q, err_q, timeout_q;
    tbre_ctrl_state_e state_q;
    logic [2:0]       kick_cnt_q;
    logic [15:0]      ack_cnt_q;
    logic             legal, status_bit, wr;
    logic             wr_start, wr_end, wr_ctrl, wr_status, kick_req, kick_ok;
    logic             bus_err, ack_expire, busy_done, wd_expire;
    logic [31:0]      rd_mux;
    logic             unused_coreout;
`ifdef TBRE_CTRL_TIMEOUT_EN
    logic [15:0]      wd_load_q, wd_cnt_q;
`endif

    assign status_bit     = mmreg_coreout_i[0];
    assign unused_coreout = &{1'b0, mmreg_coreout_i[63:1]};

    tbre_range_chk #(.AddrMin(AddrMin), .AddrMax(AddrMax)) u_range_chk (
        .start_addr(start_q),
        .end_addr  (end_q),
        .legal     (legal)
    );

    always_comb begin
        wr         = reg_req_i && reg_we_i;
        wr_start   = wr && (reg_addr_i == REG_START);
        wr_end     = wr && (reg_addr_i == REG_END);
        wr_ctrl    = wr && (reg_addr_i == REG_CTRL);
        wr_status  = wr && (reg_addr_i == REG_STATUS);
        kick_req   = wr_ctrl && reg_wdata_i[0];
        kick_ok    = kick_req && (state_q == IDLE) && legal;
        bus_err    = ((wr_start || wr_end) && (state_q != IDLE)) || (kick_req && !kick_ok);
        ack_expire = (state_q == ACK) && !status_bit && (ack_cnt_q == 16'd0);
        busy_done  = (state_q == BUSY) && !status_bit;
        wd_expire  = 1'b0;
`ifdef TBRE_CTRL_TIMEOUT_EN
        wd_expire  = (state_q == BUSY) && status_bit && (wd_cnt_q == 16'd1);
`endif
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr_i)
            REG_START:  rd_mux = start_q;
            REG_END:    rd_mux = end_q;
            REG_CTRL: begin
                rd_mux[1] = irq_en_q;
`ifdef TBRE_CTRL_TIMEOUT_EN
                rd_mux[31:16] = wd_load_q;
`endif
            end
            REG_STATUS: rd_mux[3:0] = {timeout_q, err_q, done_q, state_q != IDLE};
            default:    rd_mux = '0;
        endcase
    end

    // Register file and sticky status; hardware set wins over a same-cycle W1C
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
            start_q      <= '0;
            end_q        <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef TBRE_CTRL_TIMEOUT_EN
            wd_load_q    <= '0;
`endif
        end else begin
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= (reg_req_i && !reg_we_i) ? rd_mux : '0;
            if (wr_start && (state_q == IDLE)) start_q <= {reg_wdata_i[31:3], 3'b000};
            if (wr_end && (state_q == IDLE))   end_q   <= {reg_wdata_i[31:3], 3'b000};
            if (wr_ctrl) begin
                irq_en_q <= reg_wdata_i[1];
`ifdef TBRE_CTRL_TIMEOUT_EN
                wd_load_q <= reg_wdata_i[31:16];
`endif
            end
            done_q <= kick_ok ? 1'b0 :
                      (done_q & ~(wr_status & reg_wdata_i[ST_DONE])) | busy_done;
            err_q <= (err_q & ~(wr_status & reg_wdata_i[ST_ERR])) |
                     bus_err | ack_expire | wd_expire;
            timeout_q <= (timeout_q & ~(wr_status & reg_wdata_i[ST_TIMEOUT])) | wd_expire;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            go_q       <= 1'b0;
            kick_cnt_q <= '0;
            ack_cnt_q  <= '0;
`ifdef TBRE_CTRL_TIMEOUT_EN
            wd_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (kick_ok) begin
                    state_q    <= KICK;
                    go_q       <= 1'b1;
                    kick_cnt_q <= GoLoad;
                end
                KICK: if (kick_cnt_q == 3'd0) begin
                    state_q   <= ACK;
                    go_q      <= 1'b0;
                    ack_cnt_q <= AckLoad;
                end else begin
                    kick_cnt_q <= kick_cnt_q - 3'd1;
                end
                ACK: if (status_bit) begin
                    state_q <= BUSY;
`ifdef TBRE_CTRL_TIMEOUT_EN
                    wd_cnt_q <= wd_load_q;
`endif
                end else if (ack_cnt_q == 16'd0) begin
                    state_q <= IDLE;
                end else begin
                    ack_cnt_q <= ack_cnt_q - 16'd1;
                end
                BUSY: if (!status_bit || wd_expire) begin
                    state_q <= IDLE;
`ifdef TBRE_CTRL_TIMEOUT_EN
                end else if (wd_cnt_q != 16'd0) begin
                    wd_cnt_q <= wd_cnt_q - 16'd1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mmreg_corein_o = tbre_mmreg_in_t'{pad: '0, go: go_q, end_addr: end_q,
                                             start_addr: start_q};
    assign irq_o = irq_en_q & (done_q | err_q);

endmodule

// File: tb/tb_tbre_mmreg_ctrl.sv
// Directed bench for tbre_mmreg_ctrl: register map, kick sequencing, range
// errors, ACK wait expiry, optional watchdog and mid-walk reset.
module tb_tbre_mmreg_ctrl;

    localparam logic [3:0] A_START  = 4'h0;
    localparam logic [3:0] A_END    = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [3:0] A_STATUS = 4'hC;

    logic         clk = 1'b0;
    logic         rst;
    logic         reg_req, reg_we;
    logic [3:0]   reg_addr;
    logic [31:0]  reg_wdata, reg_rdata;
    logic         reg_rvalid;
    logic [127:0] corein;
    logic [63:0]  coreout;
    logic         irq;

    int n_pass = 0;
    int n_checks = 0;
    logic [31:0] rd;
    logic        rv;
    logic        busy_all, done_seen;
    logic [31:0] ctrl_exp;

    tbre_mmreg_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .reg_req_i      (reg_req),
        .reg_we_i       (reg_we),
        .reg_addr_i     (reg_addr),
        .reg_wdata_i    (reg_wdata),
        .reg_rdata_o    (reg_rdata),
        .reg_rvalid_o   (reg_rvalid),
        .mmreg_corein_o (corein),
        .mmreg_coreout_i(coreout),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_req = 1'b0; reg_we = 1'b0; reg_wdata = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic v);
        reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
        step();
        reg_req = 1'b0;
        d = reg_rdata;
        v = reg_rvalid;
    endtask

    initial begin
        rst = 1'b1; reg_req = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        coreout = '0;
        step(); step();
        rst = 1'b0;
        check("reset_rvalid", reg_rvalid, 1'b0);
        check("reset_corein", corein, 128'h0);
        check("reset_irq", irq, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(i * 4), rd, rv);
            check("reset_read_data", rd, 32'h0);
            check("reset_read_valid", rv, 1'b1);
        end
        step();
        check("rvalid_one_cycle", reg_rvalid, 1'b0);

        // Normal walk
        bus_write(A_START, 32'h8002_0004);
        check("write_rvalid", reg_rvalid, 1'b1);
        bus_read(A_START, rd, rv);
        check("start_mask", rd, 32'h8002_0000);
        bus_read(4'h2, rd, rv);
        check("undef_read", rd, 32'h0);
        bus_write(4'h1, 32'hffff_ffff);
        bus_read(A_START, rd, rv);
        check("undef_write_ignored", rd, 32'h8002_0000);
        bus_write(A_END, 32'h8002_0107);
        bus_read(A_END, rd, rv);
        check("end_mask", rd, 32'h8002_0100);
        bus_write(A_CTRL, 32'h3);
        check("go_t0", corein[64], 1'b1);
        check("corein_addr", corein[63:0], 64'h8002_0100_8002_0000);
        check("corein_pad", corein[127:65], 63'h0);
        step();
        check("go_t1", corein[64], 1'b1);
        step();
        check("go_t2_low", corein[64], 1'b0);
        step(); step(); step();
        coreout = 64'h1;
        busy_all = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus_read(A_STATUS, rd, rv);
            busy_all &= rd[0];
            done_seen |= rd[1];
        end
        check("busy_throughout", busy_all, 1'b1);
        check("no_early_done", done_seen, 1'b0);
        bus_read(A_CTRL, rd, rv);
        check("ctrl_go_reads0", rd, 32'h2);
        coreout = 64'h0;
        step();
        check("irq_on_done", irq, 1'b1);
        bus_read(A_STATUS, rd, rv);
        check("status_done", rd, 32'h2);
        bus_write(A_STATUS, 32'h2);
        check("irq_after_w1c", irq, 1'b0);
        bus_read(A_STATUS, rd, rv);
        check("status_cleared", rd, 32'h0);

        // Illegal ranges
        bus_write(A_START, 32'h8002_0100);
        bus_write(A_END, 32'h8002_0000);
        bus_write(A_CTRL, 32'h3);
        check("rev_no_go", corein[64], 1'b0);
        step();
        check("rev_no_go_later", corein[64], 1'b0);
        bus_read(A_STATUS, rd, rv);
        check("rev_err", rd, 32'h4);
        bus_write(A_STATUS, 32'h4);
        bus_write(A_START, 32'h7fff_fff8);
        bus_write(A_CTRL, 32'h3);
        check("low_no_go", corein[64], 1'b0);
        bus_read(A_STATUS, rd, rv);
        check("low_err", rd, 32'h4);
        bus_write(A_STATUS, 32'h4);
        bus_write(A_START, 32'h8000_0000);
        bus_write(A_END, 32'h8004_0000);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_STATUS, rd, rv);
        check("high_err", rd, 32'h4);
        bus_write(A_STATUS, 32'h4);

        // ACK wait expiry on the widest legal range
        bus_write(A_END, 32'h8003_fff8);
        bus_write(A_CTRL, 32'h3);
        check("edge_range_go", corein[64], 1'b1);
        repeat (17) step();
        check("ack_wait_early", irq, 1'b0);
        step();
        check("ack_expire_irq", irq, 1'b1);
        bus_read(A_STATUS, rd, rv);
        check("ack_expire_status", rd, 32'h4);
        bus_write(A_STATUS, 32'h4);
        bus_write(A_CTRL, 32'h3);
        repeat (4) step();
        bus_write(A_END, 32'h8000_0100);
        check("end_wr_busy_err", irq, 1'b1);
        bus_read(A_END, rd, rv);
        check("end_wr_dropped", rd, 32'h8003_fff8);
        repeat (20) step();
        bus_read(A_STATUS, rd, rv);
        check("ack_expire_idle", rd, 32'h4);
        bus_write(A_STATUS, 32'h4);

        // Watchdog field
        bus_write(A_CTRL, 32'h0008_0002);
        bus_read(A_CTRL, rd, rv);
`ifdef TBRE_CTRL_TIMEOUT_EN
        ctrl_exp = 32'h0008_0002;
`else
        ctrl_exp = 32'h0000_0002;
`endif
        check("ctrl_wd_field", rd, ctrl_exp);
`ifdef TBRE_CTRL_TIMEOUT_EN
        coreout = 64'h1;
        bus_write(A_CTRL, 32'h0008_0003);
        repeat (10) step();
        check("wd_early", irq, 1'b0);
        step();
        check("wd_expire_irq", irq, 1'b1);
        bus_read(A_STATUS, rd, rv);
        check("wd_status", rd, 32'hC);
        bus_write(A_STATUS, 32'hC);
        bus_read(A_STATUS, rd, rv);
        check("wd_status_clear", rd, 32'h0);
`endif

        // Reset mid-BUSY
        coreout = 64'h1;
        bus_write(A_CTRL, 32'h3);
        repeat (6) step();
        bus_read(A_STATUS, rd, rv);
        check("busy_before_reset", rd[0], 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_go_low", corein, 128'h0);
        check("reset_irq_low", irq, 1'b0);
        check("reset_rvalid_low", reg_rvalid, 1'b0);
        bus_read(A_STATUS, rd, rv);
        check("reset_status_zero", rd, 32'h0);
        bus_read(A_CTRL, rd, rv);
        check("reset_ctrl_zero", rd, 32'h0);
        coreout = 64'h0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tbre_mmreg_ctrl.md
Name: tbre_mmreg_ctrl

Overview:
- Memory-mapped programming front-end for the TBRE engine; sits directly upstream of the TBRE mmreg interface.
- Exposes START/END/CTRL/STATUS registers on a simple single-cycle register bus.
- Validates the requested range and drives the 128-bit mmreg_corein word with a 2-cycle go pulse.
- Tracks the TBRE status bit through kick, busy and done, and raises a sticky done/error status with an optional interrupt.

Parameters:
- GoPulseCycles, 2, cycles go is held high per kick (1..7).
- AckWaitCycles, 16, max cycles allowed from go deassertion to the status bit rising before the kick is declared failed.
- AddrMin, 32'h8000_0000, lowest legal walk address (inclusive).
- AddrMax, 32'h8003_fff8, highest legal walk address (inclusive).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- reg_req_i  in  1  register access request
- reg_we_i  in  1  1=write, 0=read
- reg_addr_i  in  4  byte offset: 0x0 START, 0x4 END, 0x8 CTRL, 0xC STATUS
- reg_wdata_i  in  32  write data
- reg_rdata_o  out  32  read data, valid the cycle after reg_req_i
- reg_rvalid_o  out  1  response valid, one cycle after every request
- mmreg_corein_o  out  128  {63'h0, go, end_addr, start_addr}
- mmreg_coreout_i  in  64  bit0 = TBRE busy status; other bits ignored
- irq_o  out  1  level interrupt = irq_en & (done | err)

Behaviour:
- Reset (rst_i sampled high on a clock edge): all registers are 0; FSM goes to IDLE; go=0, irq_o=0, reg_rvalid_o=0, reg_rdata_o=0. A reset mid-walk abandons tracking and drops go immediately.
- Bus:
  - Every request is answered the next cycle with reg_rvalid_o=1.
  - Reads of undefined offsets return 0; writes to undefined offsets are ignored.
  - Writes to START or END while FSM != IDLE are dropped and set STATUS.err.
- START and END:
  - Bits [2:0] always read 0 (writes are masked to 8-byte alignment).
  - END is inclusive.
- CTRL:
  - Bit0 go is write-1-to-kick and always reads 0.
  - Bit1 irq_en is read/write.
- STATUS:
  - Bit0 busy = (FSM != IDLE), read-only.
  - Bit1 done, sticky, W1C.
  - Bit2 err, sticky, W1C.
  - Bit3 timeout, sticky, W1C.
- Kick validation, evaluated in IDLE on a go write:
  - Legal only if start >= AddrMin, end <= AddrMax and end >= start (unsigned 32-bit compares).
  - Illegal: set err, stay in IDLE, no go pulse.
  - A go write while not IDLE sets err and is otherwise ignored.
- FSM:
  - IDLE: a legal go write moves to KICK next cycle and clears done.
  - KICK: go=1 for exactly GoPulseCycles cycles (3-bit counter), then go to ACK.
  - ACK: if status bit0=1, go to BUSY. Otherwise count down from AckWaitCycles; at 0, set err and return to IDLE.
  - BUSY: when status bit0=0, set done and go to IDLE.
  - If the status bit is already 1 during KICK, the FSM still completes the pulse and then proceeds to BUSY via ACK in one cycle.
- Simultaneous events: a W1C of done in the same cycle as a hardware set of done leaves done=1 (set wins). The same rule applies to err and timeout.
- mmreg_corein_o is registered and changes only from START/END/go register state; no combinational path from the bus.

Optional Feature:
- Macro: TBRE_CTRL_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in BUSY; it is reloaded from CTRL[31:16] on entry to BUSY.
  - On expiry: set timeout and err, leave BUSY to IDLE, do not set done.
  - A CTRL[31:16] value of 0 disables the watchdog.
- Undefined:
  - CTRL[31:16] reads 0 and STATUS.timeout reads 0.
  - BUSY waits indefinitely.

Decomposition:
- Add to cheri_pkg or a new tbre_pkg:
  - register offset localparams;
  - the STATUS bit index constants;
  - a packed tbre_mmreg_in_t struct {pad63, go, end_addr, start_addr}, cast to 128 bits.
- FSM enum tbre_ctrl_state_e {IDLE, KICK, ACK, BUSY} lives in the same package.
- One sub-module: tbre_range_chk, a combinational legality check of start/end against AddrMin/AddrMax. The sequencing stays in the top module.

Test Plan:
- Reset then read all offsets -> every read is 0 with reg_rvalid_o=1 one cycle after the request.
- Write START=0x8002_0004, END=0x8002_0107, go -> START reads 0x8002_0000; go is high exactly 2 cycles; corein[63:0]={0x8002_0100,0x8002_0000}.
- Model TBRE raises status 3 cycles after go falls, holds it 40 cycles -> busy=1 throughout; then done=1 and irq_o=1 (irq_en=1); W1C done -> irq_o=0.
- START=0x8002_0100, END=0x8002_0000, go -> err=1, no go pulse, FSM stays IDLE; same result for START=0x7fff_fff8.
- Status never rises -> err=1 after 2+16 cycles, FSM back to IDLE; a write to END while in ACK is dropped and sets err.
- With TBRE_CTRL_TIMEOUT_EN, CTRL[31:16]=8 and status held high -> timeout=1 and err=1 after 8 BUSY cycles, done=0; a rst_i pulse mid-BUSY -> go=0 and all STATUS bits 0 the next cycle.
